// File: rtl/ota_pkg.sv
// Shared types and constants for the off-target match core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ota_pkg;

  localparam int OTA_GUIDE_LEN = 20;
  localparam int OTA_POS_W     = 32;
  localparam int OTA_MM_W      = $clog2(OTA_GUIDE_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ota_state_t;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  typedef struct packed {
    logic [OTA_POS_W-1:0] pos;
    logic [OTA_MM_W-1:0]  mm;
  } ota_hit_t;

endpackage

// File: rtl/ota_mismatch_count.sv
// Counts bases where the window differs from the guide (2-bit inequality popcount).
// Latency: purely combinational.
// Backpressure: none.
module ota_mismatch_count #(
  parameter int GUIDE_LEN = 20,
  parameter int MM_W      = $clog2(GUIDE_LEN + 1)
) (
  input  logic [2*GUIDE_LEN-1:0] window,
  input  logic [2*GUIDE_LEN-1:0] guide,
  output logic [MM_W-1:0]        mm
);

  // Popcount of per-base mismatches.
  always_comb begin
    mm = '0;
    for (int i = 0; i < GUIDE_LEN; i++) begin
      if (window[2*i +: 2] != guide[2*i +: 2]) begin
        mm = mm + MM_W'(1);
      end
    end
  end

endmodule

// File: rtl/ota_match_engine.sv
// Slides a guide-length window over a base stream and emits (pos, mm) hit records.
// Latency: hit_valid_o rises the cycle after the accept that completes a matching window.
// Backpressure: base_ready_o drops while a hit is held with hit_ready_i low; no hit is lost.
module ota_match_engine
  import ota_pkg::*;
#(
  parameter int GUIDE_LEN = 20,
  parameter int POS_W     = 32,
  parameter int MM_W      = $clog2(GUIDE_LEN + 1)
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   start_i,
  input  logic [2*GUIDE_LEN-1:0] guide_i,
  input  logic [MM_W-1:0]        max_mm_i,
  input  logic [POS_W-1:0]       genome_len_i,
  input  logic [1:0]             base_data_i,
  input  logic                   base_valid_i,
  output logic                   base_ready_o,
  output logic [POS_W-1:0]       hit_pos_o,
  output logic [MM_W-1:0]        hit_mm_o,
  output logic                   hit_valid_o,
  input  logic                   hit_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [POS_W-1:0]       hit_count_o
);

  localparam int              WIN_W     = 2 * GUIDE_LEN;
  localparam logic [MM_W-1:0] FILL_FULL = MM_W'(GUIDE_LEN);

  ota_state_t        state, state_nxt;
  logic [WIN_W-1:0]  window, window_shift, guide_q;
  logic [MM_W-1:0]   max_mm_q, fill, fill_nxt, mm;
  logic [POS_W-1:0]  len_q, base_idx;
  logic              start_ok, accept, last_base, hit_load;

  // Start is only honoured when no run is in flight.
  assign start_ok     = start_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign base_ready_o = (state == ST_RUN) && (!hit_valid_o || hit_ready_i);
  assign accept       = base_valid_i && base_ready_o;
  // Newest base enters at the top so the oldest base sits at [1:0], lined up with the guide's 5' base.
  assign window_shift = {base_data_i, window[WIN_W-1:2]};
  assign fill_nxt     = (fill == FILL_FULL) ? fill : fill + MM_W'(1);
  // len_q is never zero in RUN, so the subtraction cannot wrap.
  assign last_base    = (base_idx == len_q - POS_W'(1));
  assign hit_load     = accept && (fill_nxt == FILL_FULL) && (mm <= max_mm_q);
  assign busy_o       = (state == ST_RUN) || (state == ST_DRAIN);
  assign done_o       = (state == ST_DONE);

  ota_mismatch_count #(
    .GUIDE_LEN (GUIDE_LEN),
    .MM_W      (MM_W)
  ) u_mm (
    .window (window_shift),
    .guide  (guide_q),
    .mm     (mm)
  );

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_i) state_nxt = (genome_len_i == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (accept && last_base) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!hit_valid_o || hit_ready_i) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run configuration, window shift register and base/fill counters.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      guide_q  <= '0;
      max_mm_q <= '0;
      len_q    <= '0;
      window   <= '0;
      base_idx <= '0;
      fill     <= '0;
    end else if (start_ok) begin
      guide_q  <= guide_i;
      max_mm_q <= max_mm_i;
      len_q    <= genome_len_i;
      base_idx <= '0;
      fill     <= '0;
    end else if (accept) begin
      window   <= window_shift;
      base_idx <= base_idx + POS_W'(1);
      fill     <= fill_nxt;
    end
  end

  // Hit output register: loading takes priority over the drain of the previous record.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      hit_valid_o <= 1'b0;
      hit_pos_o   <= '0;
      hit_mm_o    <= '0;
    end else if (hit_load) begin
      hit_valid_o <= 1'b1;
      hit_pos_o   <= base_idx - POS_W'(GUIDE_LEN - 1);
      hit_mm_o    <= mm;
    end else if (hit_ready_i) begin
      hit_valid_o <= 1'b0;
    end
  end

  // Saturating count of hits loaded since the last start.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      hit_count_o <= '0;
    end else if (start_ok) begin
      hit_count_o <= '0;
    end else if (hit_load && (hit_count_o != '1)) begin
      hit_count_o <= hit_count_o + POS_W'(1);
    end
  end

endmodule

// File: tb/tb_ota_match_engine.sv
// Directed bench for ota_match_engine with a 4-base guide.
// Latency: n/a.
// Backpressure: exercised via hit_ready_i stalls.
module tb_ota_match_engine;
  import ota_pkg::*;

  localparam int GL    = 4;
  localparam int POS_W = 32;
  localparam int MM_W  = 3;

  logic             ACLK = 1'b0;
  logic             ARESET = 1'b1;
  logic             start_i = 1'b0;
  logic [2*GL-1:0]  guide_i = '0;
  logic [MM_W-1:0]  max_mm_i = '0;
  logic [POS_W-1:0] genome_len_i = '0;
  logic [1:0]       base_data_i = '0;
  logic             base_valid_i = 1'b0;
  logic             base_ready_o;
  logic [POS_W-1:0] hit_pos_o;
  logic [MM_W-1:0]  hit_mm_o;
  logic             hit_valid_o;
  logic             hit_ready_i = 1'b1;
  logic             busy_o;
  logic             done_o;
  logic [POS_W-1:0] hit_count_o;

  ota_match_engine #(.GUIDE_LEN(GL), .POS_W(POS_W), .MM_W(MM_W)) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .start_i      (start_i),
    .guide_i      (guide_i),
    .max_mm_i     (max_mm_i),
    .genome_len_i (genome_len_i),
    .base_data_i  (base_data_i),
    .base_valid_i (base_valid_i),
    .base_ready_o (base_ready_o),
    .hit_pos_o    (hit_pos_o),
    .hit_mm_o     (hit_mm_o),
    .hit_valid_o  (hit_valid_o),
    .hit_ready_i  (hit_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .hit_count_o  (hit_count_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] pos;
    logic [31:0] mm;
  } hit_rec_t;

  typedef struct {
    string name;
    string guide;
    int    max_mm;
    int    len;
    string stream;
    int    n;
    int    p0, m0, p1, m1;
    int    cnt;
  } vec_t;

  hit_rec_t hits[$];
  int       acc_cnt = 0;
  int       tests = 0;
  int       fails = 0;

  // Record every completed hit handshake and every accepted base.
  always @(posedge ACLK) begin
    if (hit_valid_o && hit_ready_i) hits.push_back('{pos: hit_pos_o, mm: 32'(hit_mm_o)});
    if (base_valid_i && base_ready_o) acc_cnt <= acc_cnt + 1;
  end

  function automatic logic [63:0] enc(input string s);
    logic [63:0] r = '0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "A": r[2*i +: 2] = BASE_A;
        "C": r[2*i +: 2] = BASE_C;
        "G": r[2*i +: 2] = BASE_G;
        default: r[2*i +: 2] = BASE_T;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_start(input string g, input int mm, input int len);
    logic [63:0] gb;
    gb = enc(g);
    hits.delete();
    guide_i      = gb[2*GL-1:0];
    max_mm_i     = MM_W'(mm);
    genome_len_i = POS_W'(len);
    start_i      = 1'b1;
    @(posedge ACLK); #1;
    start_i      = 1'b0;
  endtask

  task automatic feed(input string s);
    logic [63:0] sb;
    int n, t;
    bit ok;
    sb = enc(s);
    ok = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      base_data_i  = sb[2*i +: 2];
      base_valid_i = 1'b1;
      n = acc_cnt;
      t = 0;
      while (acc_cnt == n && t < 100) begin
        @(posedge ACLK); #1;
        t++;
      end
      if (acc_cnt == n) ok = 1'b0;
    end
    base_valid_i = 1'b0;
    chk("base_accept_in_time", 64'(ok), 64'd1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done_o && t < 200) begin
      @(posedge ACLK); #1;
      t++;
    end
  endtask

  task automatic check_hits(input string nm, input int n, input int p0, input int m0,
                            input int p1, input int m1, input int cnt);
    int ep[2];
    int em[2];
    ep[0] = p0; ep[1] = p1; em[0] = m0; em[1] = m1;
    chk({nm, "_nhits"}, 64'(hits.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      chk({nm, "_pos"}, (k < hits.size()) ? 64'(hits[k].pos) : '1, 64'(ep[k]));
      chk({nm, "_mm"},  (k < hits.size()) ? 64'(hits[k].mm)  : '1, 64'(em[k]));
    end
    chk({nm, "_hit_count"}, 64'(hit_count_o), 64'(cnt));
    chk({nm, "_done"}, 64'(done_o), 64'd1);
    chk({nm, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_base_ready"}, 64'(base_ready_o), 64'd0);
    chk({nm, "_hit_valid"},  64'(hit_valid_o),  64'd0);
    chk({nm, "_hit_pos"},    64'(hit_pos_o),    64'd0);
    chk({nm, "_hit_mm"},     64'(hit_mm_o),     64'd0);
    chk({nm, "_busy"},       64'(busy_o),       64'd0);
    chk({nm, "_done"},       64'(done_o),       64'd0);
    chk({nm, "_hit_count"},  64'(hit_count_o),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   a0, t, p, m;
    bit   stable_ok, rdy_low_ok;

    vecs[0] = '{"exact",      "ACGT", 0, 6, "ACGTAC",   1, 0, 0, 0, 0, 1};
    vecs[1] = '{"one_mm",     "ACGT", 1, 8, "TCGTACGT", 2, 0, 1, 4, 0, 2};
    vecs[2] = '{"short",      "ACGT", 0, 3, "ACG",      0, 0, 0, 0, 0, 0};
    vecs[3] = '{"mm_incl",    "ACGT", 4, 5, "ACGTA",    2, 0, 0, 1, 4, 2};
    vecs[4] = '{"mm_excl",    "ACGT", 3, 5, "ACGTA",    1, 0, 0, 0, 0, 1};

    #3;
    check_reset_vals("reset");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Table-driven scenarios with hit_ready held high.
    for (int r = 0; r < 5; r++) begin
      hit_ready_i = 1'b1;
      do_start(vecs[r].guide, vecs[r].max_mm, vecs[r].len);
      chk({vecs[r].name, "_ready_after_start"}, 64'(base_ready_o), 64'd1);
      feed(vecs[r].stream);
      wait_done();
      check_hits(vecs[r].name, vecs[r].n, vecs[r].p0, vecs[r].m0,
                 vecs[r].p1, vecs[r].m1, vecs[r].cnt);
    end

    // Hit stall: hold the first hit for 10 cycles.
    hit_ready_i = 1'b1;
    do_start("ACGT", 1, 8);
    fork
      feed("TCGTACGT");
      begin
        t = 0;
        while (!hit_valid_o && t < 100) begin
          @(posedge ACLK); #1;
          t++;
        end
        hit_ready_i = 1'b0;
        p = 32'(hit_pos_o);
        m = 32'(hit_mm_o);
        stable_ok  = hit_valid_o;
        rdy_low_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(posedge ACLK); #1;
          if (!hit_valid_o || hit_pos_o != 32'(p) || 32'(hit_mm_o) != m) stable_ok = 1'b0;
          if (base_ready_o) rdy_low_ok = 1'b0;
        end
        chk("stall_hit_stable", 64'(stable_ok), 64'd1);
        chk("stall_base_ready_low", 64'(rdy_low_ok), 64'd1);
        chk("stall_held_pos", 64'(p), 64'd0);
        hit_ready_i = 1'b1;
      end
    join
    wait_done();
    check_hits("stall", 2, 0, 1, 4, 0, 2);

    // Zero-length genome: done immediately, no base accepted.
    do_start("ACGT", 0, 0);
    chk("len0_done", 64'(done_o), 64'd1);
    chk("len0_hit_count_cleared", 64'(hit_count_o), 64'd0);
    a0 = acc_cnt;
    base_valid_i = 1'b1;
    rdy_low_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (base_ready_o) rdy_low_ok = 1'b0;
      @(posedge ACLK); #1;
    end
    base_valid_i = 1'b0;
    chk("len0_never_ready", 64'(rdy_low_ok), 64'd1);
    chk("len0_no_accept", 64'(acc_cnt - a0), 64'd0);

    // Reset mid-run with a hit pending.
    hit_ready_i = 1'b1;
    do_start("ACGT", 4, 8);
    feed("TCGTA");
    hit_ready_i = 1'b0;
    chk("prereset_hit_pending", 64'(hit_valid_o), 64'd1);
    #2 ARESET = 1'b1;
    #1 check_reset_vals("midreset");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    hit_ready_i = 1'b1;
    @(posedge ACLK); #1;
    do_start("ACGT", 1, 8);
    feed("TCGTACGT");
    wait_done();
    check_hits("after_reset", 2, 0, 1, 4, 0, 2);

    // Start pulsed mid-run with a different configuration is ignored.
    do_start("ACGT", 1, 8);
    a0 = acc_cnt;
    fork
      feed("TCGTACGT");
      begin
        t = 0;
        while (acc_cnt < a0 + 3 && t < 100) begin
          @(posedge ACLK); #1;
          t++;
        end
        guide_i      = 8'hFF;
        max_mm_i     = 3'd0;
        genome_len_i = 32'd3;
        start_i      = 1'b1;
        @(posedge ACLK); #1;
        start_i      = 1'b0;
        chk("midstart_still_busy", 64'(busy_o), 64'd1);
      end
    join
    wait_done();
    check_hits("midstart", 2, 0, 1, 4, 0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
